norm_acc: RTL

NORM_ACC -- requirements
Module: norm_acc

---
 rtl/norm_acc.sv | 122 ++++++++++++
 1 files changed

// File: rtl/norm_acc.sv
// Streaming sum-of-squares accumulator with floor integer square root output.
// Optional NORM_ACC_SAT_EN: saturate the accumulator and raise a sticky overflow flag.
module norm_acc #(
  parameter  int IN_W  = 8,
  parameter  int ACC_W = 20,
  parameter  int CNT_W = 8,
  localparam int OUT_W = (ACC_W + 1) / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             clear_in,
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] g,
  output logic             valid_out,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int RW = OUT_W + 2;

  logic             s1_v_q, s1_clr_q;
  logic [IN_W-1:0]  s1_a_q;
  logic             s2_v_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] g_q, root_d;
  logic [CNT_W-1:0] cnt_out_q;
  logic             ovf_out_q, vout_q;

  logic [2*IN_W-1:0] sq;
  logic [ACC_W-1:0]  sq_ext, base;

  assign sq     = {{IN_W{1'b0}}, s1_a_q} * {{IN_W{1'b0}}, s1_a_q};
  assign sq_ext = ACC_W'(sq);
  // A clear sample restarts from zero rather than from the running sum.
  assign base   = s1_clr_q ? '0 : acc_q;

`ifdef NORM_ACC_SAT_EN
  logic [ACC_W:0] sum;
  always_comb begin
    sum   = {1'b0, base} + {1'b0, sq_ext};
    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    ovf_d = (s1_clr_q ? 1'b0 : ovf_q) | sum[ACC_W];
  end
`else
  always_comb begin
    acc_d = base + sq_ext;
    ovf_d = 1'b0;
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (s1_clr_q)
      cnt_d = CNT_W'(1);
    else if (cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Digit-by-digit integer square root, two radicand bits per result bit.
  logic [2*OUT_W-1:0] rad;
  logic [RW-1:0]      rem, trial;
  always_comb begin
    rad            = '0;
    rad[ACC_W-1:0] = acc_q;
    rem            = '0;
    trial          = '0;
    root_d         = '0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      rem   = {rem[RW-3:0], rad[2*i +: 2]};
      trial = {root_d, 2'b01};
      if (rem >= trial) begin
        rem    = rem - trial;
        root_d = {root_d[OUT_W-2:0], 1'b1};
      end else begin
        root_d = {root_d[OUT_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_clr_q  <= 1'b0;
      s1_a_q    <= '0;
      s2_v_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      g_q       <= '0;
      cnt_out_q <= '0;
      ovf_out_q <= 1'b0;
      vout_q    <= 1'b0;
    end else begin
      s1_v_q <= valid_in;
      if (valid_in) begin
        s1_a_q   <= a;
        s1_clr_q <= clear_in;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
      vout_q <= s2_v_q;
      if (s2_v_q) begin
        g_q       <= root_d;
        cnt_out_q <= cnt_q;
        ovf_out_q <= ovf_q;
      end
    end
  end

  assign g         = g_q;
  assign count     = cnt_out_q;
  assign overflow  = ovf_out_q;
  assign valid_out = vout_q;

endmodule
